// File: rtl/bp_cce_uc_sequencer_pkg.sv
// Shared configuration and state encoding for the CCE uncached-request sequencer.
package bp_cce_uc_sequencer_pkg;

  localparam int unsigned num_lce_gp      = 4;
  localparam int unsigned lce_id_width_gp = 2;
  localparam int unsigned paddr_width_gp  = 40;
  localparam int unsigned caddr_width_gp  = 32;
  localparam logic [paddr_width_gp-1:0] dram_base_addr_gp = 40'h00_8000_0000;

  typedef enum logic [2:0] {
    e_idle     = 3'd0,
    e_inv      = 3'd1,
    e_ack_wait = 3'd2,
    e_mem      = 3'd3,
    e_mem_wait = 3'd4,
    e_done     = 3'd5
  } bp_cce_uc_seq_state_e;

endpackage

// File: rtl/bp_cce_uc_sequencer_pma.sv
// Physical memory attribute check: global DRAM is the only cacheable region.
module bp_cce_pma
  import bp_cce_uc_sequencer_pkg::*;
#(
  parameter int unsigned               paddr_width_p    = paddr_width_gp,
  parameter int unsigned               caddr_width_p    = caddr_width_gp,
  parameter logic [paddr_width_p-1:0]  dram_base_addr_p = paddr_width_p'(dram_base_addr_gp)
) (
  input  logic [paddr_width_p-1:0] paddr_i,
  output logic                     cacheable_addr_o
);

  localparam logic [paddr_width_p-1:0] lp_dram_limit = paddr_width_p'(1) << caddr_width_p;

  assign cacheable_addr_o = (paddr_i >= dram_base_addr_p) && (paddr_i < lp_dram_limit);

endmodule

// File: rtl/bp_cce_uc_sequencer.sv
// Sequences one uncached LCE request: optional invalidate-all with ack collection,
// then a single memory command, then a one-cycle completion pulse.
module bp_cce_uc_sequencer
  import bp_cce_uc_sequencer_pkg::*;
#(
  parameter int unsigned              num_lce_p        = num_lce_gp,
  parameter int unsigned              lce_id_width_p   = lce_id_width_gp,
  parameter int unsigned              paddr_width_p    = paddr_width_gp,
  parameter int unsigned              caddr_width_p    = caddr_width_gp,
  parameter logic [paddr_width_p-1:0] dram_base_addr_p = paddr_width_p'(dram_base_addr_gp),
  localparam int unsigned             ack_cnt_width_lp = $clog2(num_lce_p + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      req_v_i,
  output logic                      req_ready_and_o,
  input  logic [paddr_width_p-1:0]  req_addr_i,
  input  logic                      req_wr_i,
  output logic                      inv_v_o,
  input  logic                      inv_ready_and_i,
  output logic [lce_id_width_p-1:0] inv_lce_o,
  output logic [paddr_width_p-1:0]  inv_addr_o,
  input  logic                      ack_v_i,
  output logic                      mem_v_o,
  input  logic                      mem_ready_and_i,
  output logic [paddr_width_p-1:0]  mem_addr_o,
  output logic                      mem_wr_o,
  input  logic                      mem_done_i,
  output logic                      done_v_o,
  output logic                      busy_o
);

  localparam logic [ack_cnt_width_lp-1:0] lp_ack_max  = ack_cnt_width_lp'(num_lce_p);
  localparam logic [lce_id_width_p-1:0]   lp_lce_last = lce_id_width_p'(num_lce_p - 1);

  bp_cce_uc_seq_state_e          r_state;
  logic [paddr_width_p-1:0]      r_addr;
  logic                          r_wr;
  logic [lce_id_width_p-1:0]     r_lce_cnt;
  logic [ack_cnt_width_lp-1:0]   r_ack_cnt;

  logic                          w_cacheable;
  logic                          w_ack_inc;
  logic [ack_cnt_width_lp-1:0]   w_ack_cnt_next;
  logic                          w_ack_full_next;

  bp_cce_pma #(
    .paddr_width_p   (paddr_width_p),
    .caddr_width_p   (caddr_width_p),
    .dram_base_addr_p(dram_base_addr_p)
  ) u_pma (
    .paddr_i         (req_addr_i),
    .cacheable_addr_o(w_cacheable)
  );

  // Ack count including any ack in the current cycle, saturating at num_lce_p.
  assign w_ack_inc       = ack_v_i && (r_ack_cnt != lp_ack_max);
  assign w_ack_cnt_next  = r_ack_cnt + ack_cnt_width_lp'(w_ack_inc);
  assign w_ack_full_next = (w_ack_cnt_next == lp_ack_max);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state   <= e_idle;
      r_addr    <= '0;
      r_wr      <= 1'b0;
      r_lce_cnt <= '0;
      r_ack_cnt <= '0;
    end else begin
      case (r_state)
        e_idle: begin
          if (req_v_i) begin
            r_addr    <= req_addr_i;
            r_wr      <= req_wr_i;
            r_lce_cnt <= '0;
            r_ack_cnt <= '0;
            r_state   <= w_cacheable ? e_inv : e_mem;
          end
        end
        e_inv: begin
          r_ack_cnt <= w_ack_cnt_next;
          if (inv_ready_and_i) begin
            r_lce_cnt <= r_lce_cnt + lce_id_width_p'(1);
            if (r_lce_cnt == lp_lce_last) begin
              r_state <= w_ack_full_next ? e_mem : e_ack_wait;
            end
          end
        end
        e_ack_wait: begin
          r_ack_cnt <= w_ack_cnt_next;
          if (w_ack_full_next) begin
            r_state <= e_mem;
          end
        end
        e_mem: begin
          if (mem_ready_and_i) begin
            r_state <= e_mem_wait;
          end
        end
        e_mem_wait: begin
          if (mem_done_i) begin
            r_state <= e_done;
          end
        end
        e_done:  r_state <= e_idle;
        default: r_state <= e_idle;
      endcase
    end
  end

  // Outputs decode registered state only; ready is additionally gated by reset.
  assign req_ready_and_o = reset_n_i && (r_state == e_idle);
  assign inv_v_o         = (r_state == e_inv);
  assign inv_lce_o       = r_lce_cnt;
  assign inv_addr_o      = r_addr;
  assign mem_v_o         = (r_state == e_mem);
  assign mem_addr_o      = r_addr;
  assign mem_wr_o        = r_wr;
  assign done_v_o        = (r_state == e_done);
  assign busy_o          = (r_state != e_idle);

endmodule

// File: tb/tb_bp_cce_uc_sequencer.sv
// Directed, table-driven check of the uncached-request sequencer with four LCEs.
module tb_bp_cce_uc_sequencer;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        req_v_i;
  logic        req_ready_and_o;
  logic [39:0] req_addr_i;
  logic        req_wr_i;
  logic        inv_v_o;
  logic        inv_ready_and_i;
  logic [1:0]  inv_lce_o;
  logic [39:0] inv_addr_o;
  logic        ack_v_i;
  logic        mem_v_o;
  logic        mem_ready_and_i;
  logic [39:0] mem_addr_o;
  logic        mem_wr_o;
  logic        mem_done_i;
  logic        done_v_o;
  logic        busy_o;

  always #5 clk_i = ~clk_i;

  bp_cce_uc_sequencer dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .req_v_i        (req_v_i),
    .req_ready_and_o(req_ready_and_o),
    .req_addr_i     (req_addr_i),
    .req_wr_i       (req_wr_i),
    .inv_v_o        (inv_v_o),
    .inv_ready_and_i(inv_ready_and_i),
    .inv_lce_o      (inv_lce_o),
    .inv_addr_o     (inv_addr_o),
    .ack_v_i        (ack_v_i),
    .mem_v_o        (mem_v_o),
    .mem_ready_and_i(mem_ready_and_i),
    .mem_addr_o     (mem_addr_o),
    .mem_wr_o       (mem_wr_o),
    .mem_done_i     (mem_done_i),
    .done_v_o       (done_v_o),
    .busy_o         (busy_o)
  );

  typedef struct {
    string       name;
    logic        req_v;
    logic [39:0] addr;
    logic        wr;
    logic        inv_rdy;
    logic        ack;
    logic        mem_rdy;
    logic        mem_done;
    logic        e_rdy;
    logic        e_busy;
    logic        e_inv;
    logic [1:0]  e_lce;
    logic        e_mem;
    logic        e_done;
    logic [39:0] e_addr;
    logic        e_wr;
  } vec_t;

  localparam logic [39:0] UA  = 40'h00_0010_0000;
  localparam logic [39:0] UA2 = 40'h00_0020_0000;
  localparam logic [39:0] CA  = 40'h00_8000_0040;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_inv_hs = 0;
  vec_t tbl[$];

  always @(posedge clk_i) begin
    if (reset_n_i && inv_v_o && inv_ready_and_i) n_inv_hs <= n_inv_hs + 1;
  end

  function automatic vec_t mk(input string nm, input logic rv, input logic [39:0] a, input logic w,
                              input logic ir, input logic ak, input logic mr, input logic md,
                              input logic erd, input logic eb, input logic ei, input logic [1:0] el,
                              input logic em, input logic ed, input logic [39:0] ea, input logic ew);
    vec_t v;
    v.name = nm; v.req_v = rv; v.addr = a; v.wr = w; v.inv_rdy = ir; v.ack = ak;
    v.mem_rdy = mr; v.mem_done = md; v.e_rdy = erd; v.e_busy = eb; v.e_inv = ei;
    v.e_lce = el; v.e_mem = em; v.e_done = ed; v.e_addr = ea; v.e_wr = ew;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Entered just after a rising edge: drive this cycle's inputs, check, advance one cycle.
  task automatic cyc(input vec_t v);
    req_v_i = v.req_v; req_addr_i = v.addr; req_wr_i = v.wr;
    inv_ready_and_i = v.inv_rdy; ack_v_i = v.ack;
    mem_ready_and_i = v.mem_rdy; mem_done_i = v.mem_done;
    #1;
    chk({v.name, " ready"}, 64'(req_ready_and_o), 64'(v.e_rdy));
    chk({v.name, " busy"},  64'(busy_o),          64'(v.e_busy));
    chk({v.name, " inv_v"}, 64'(inv_v_o),         64'(v.e_inv));
    chk({v.name, " mem_v"}, 64'(mem_v_o),         64'(v.e_mem));
    chk({v.name, " done"},  64'(done_v_o),        64'(v.e_done));
    if (v.e_inv) chk({v.name, " inv_lce"}, 64'(inv_lce_o), 64'(v.e_lce));
    if (v.e_busy) begin
      chk({v.name, " mem_addr"}, 64'(mem_addr_o), 64'(v.e_addr));
      chk({v.name, " inv_addr"}, 64'(inv_addr_o), 64'(v.e_addr));
      chk({v.name, " mem_wr"},   64'(mem_wr_o),   64'(v.e_wr));
    end
    @(posedge clk_i); #1;
  endtask

  initial begin
    logic got;
    reset_n_i = 1'b0; req_v_i = 1'b0; req_addr_i = '0; req_wr_i = 1'b0;
    inv_ready_and_i = 1'b0; ack_v_i = 1'b0; mem_ready_and_i = 1'b0; mem_done_i = 1'b0;

    //        name     rv addr wr ir ak mr md  rdy bsy inv lce mem done e_addr e_wr
    // uncacheable store
    tbl.push_back(mk("unc0", 1, UA, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, UA, 1));
    tbl.push_back(mk("unc1", 0, 0,  0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, UA, 1));
    tbl.push_back(mk("unc2", 0, 0,  0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, UA, 1));
    tbl.push_back(mk("unc3", 0, 0,  0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, UA, 1));
    tbl.push_back(mk("unc4", 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, UA, 1));
    tbl.push_back(mk("unc5", 0, 0,  0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, UA, 1));
    // cacheable load, inv ready always high, stray acks in idle/e_mem/e_mem_wait
    tbl.push_back(mk("cld0",  1, CA, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, CA, 0));
    tbl.push_back(mk("cld1",  0, 0,  0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, CA, 0));
    tbl.push_back(mk("cld2",  0, 0,  0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0, CA, 0));
    tbl.push_back(mk("cld3",  0, 0,  0, 1, 0, 0, 0, 0, 1, 1, 2, 0, 0, CA, 0));
    tbl.push_back(mk("cld4",  0, 0,  0, 1, 0, 0, 0, 0, 1, 1, 3, 0, 0, CA, 0));
    tbl.push_back(mk("cld5",  0, 0,  0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, CA, 0));
    tbl.push_back(mk("cld6",  0, 0,  0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, CA, 0));
    tbl.push_back(mk("cld7",  0, 0,  0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, CA, 0));
    tbl.push_back(mk("cld8",  0, 0,  0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, CA, 0));
    tbl.push_back(mk("cld9",  0, 0,  0, 1, 1, 1, 0, 0, 1, 0, 0, 1, 0, CA, 0));
    tbl.push_back(mk("cld10", 0, 0,  0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, CA, 0));
    tbl.push_back(mk("cld11", 0, 0,  0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, CA, 0));
    tbl.push_back(mk("cld12", 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, CA, 0));
    tbl.push_back(mk("cld13", 0, 0,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, CA, 0));
    // back-pressure at LCE 2, all acks during e_inv, last ack with last handshake
    tbl.push_back(mk("bp0",  1, CA, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, CA, 1));
    tbl.push_back(mk("bp1",  0, 0,  0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, CA, 1));
    tbl.push_back(mk("bp2",  0, 0,  0, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, CA, 1));
    tbl.push_back(mk("bp3",  0, 0,  0, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0, CA, 1));
    tbl.push_back(mk("bp4",  0, 0,  0, 0, 1, 0, 0, 0, 1, 1, 2, 0, 0, CA, 1));
    tbl.push_back(mk("bp5",  0, 0,  0, 0, 1, 0, 0, 0, 1, 1, 2, 0, 0, CA, 1));
    tbl.push_back(mk("bp6",  0, 0,  0, 1, 0, 0, 0, 0, 1, 1, 2, 0, 0, CA, 1));
    tbl.push_back(mk("bp7",  0, 0,  0, 1, 1, 0, 0, 0, 1, 1, 3, 0, 0, CA, 1));
    tbl.push_back(mk("bp8",  0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, CA, 1));
    tbl.push_back(mk("bp9",  0, 0,  0, 0, 0, 1, 1, 0, 1, 0, 0, 1, 0, CA, 1));
    tbl.push_back(mk("bp10", 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, CA, 1));
    tbl.push_back(mk("bp11", 0, 0,  0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, CA, 1));
    tbl.push_back(mk("bp12", 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, CA, 1));
    tbl.push_back(mk("bp13", 0, 0,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, CA, 1));
    // back-to-back with req_v held high; second accepted only after done
    tbl.push_back(mk("b2b0", 1, UA,  1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, UA,  1));
    tbl.push_back(mk("b2b1", 1, UA2, 0, 0, 0, 1, 1, 0, 1, 0, 0, 1, 0, UA,  1));
    tbl.push_back(mk("b2b2", 1, UA2, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, UA,  1));
    tbl.push_back(mk("b2b3", 1, UA2, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 1, UA,  1));
    tbl.push_back(mk("b2b4", 1, UA2, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, UA,  1));
    tbl.push_back(mk("b2b5", 0, 0,   0, 0, 0, 1, 1, 0, 1, 0, 0, 1, 0, UA2, 0));
    tbl.push_back(mk("b2b6", 0, 0,   0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, UA2, 0));
    tbl.push_back(mk("b2b7", 0, 0,   0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, UA2, 0));
    tbl.push_back(mk("b2b8", 0, 0,   0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, UA2, 0));

    // reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst ready", 64'(req_ready_and_o), 64'd0);
    chk("rst busy",  64'(busy_o),          64'd0);
    chk("rst valids", 64'({inv_v_o, mem_v_o, done_v_o}), 64'd0);
    chk("rst addr",  64'(mem_addr_o),      64'd0);
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;

    foreach (tbl[i]) cyc(tbl[i]);
    chk("inv handshakes", 64'(n_inv_hs), 64'd8);

    // reset in e_ack_wait
    cyc(mk("mr0", 1, CA, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, CA, 1));
    for (int i = 0; i < 4; i++)
      cyc(mk("mr_inv", 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 2'(i), 0, 0, CA, 1));
    cyc(mk("mr_ack", 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, CA, 1));
    cyc(mk("mr_ack", 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, CA, 1));
    ack_v_i = 1'b1;
    #2 reset_n_i = 1'b0;
    #1;
    chk("mr async ready", 64'(req_ready_and_o), 64'd0);
    chk("mr async busy",  64'(busy_o),          64'd0);
    chk("mr async valids", 64'({inv_v_o, mem_v_o, done_v_o}), 64'd0);
    chk("mr async addr",  64'(inv_addr_o),      64'd0);
    @(posedge clk_i); #1;
    chk("mr held ready", 64'(req_ready_and_o), 64'd0);
    reset_n_i = 1'b1;
    #1;
    chk("mr rel ready", 64'(req_ready_and_o), 64'd1);
    @(posedge clk_i); #1;
    for (int i = 0; i < 3; i++)
      cyc(mk("mr_stray", 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));

    // next request must complete normally within a bounded number of cycles
    cyc(mk("mr_req", 1, UA, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, UA, 1));
    req_v_i = 1'b0;
    got = 1'b0;
    chk("mr_req mem_addr", 64'(mem_addr_o), 64'(UA));
    for (int i = 0; i < 20 && !got; i++) begin
      if (done_v_o) got = 1'b1;
      else begin @(posedge clk_i); #1; end
    end
    chk("mr_req done seen", 64'(got), 64'd1);
    @(posedge clk_i); #1;
    chk("mr_req idle", 64'({busy_o, done_v_o}), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
